// File: rtl/uart_pkg.sv
// Shared UART1 definitions: frame geometry, line levels and the FSM state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart1_rx.sv
// UART1 receiver: 8 data bits LSB-first, even parity, one stop bit, delivered
// on a valid/ready port with parity, framing and overrun flags.
module uart1_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx1,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_active
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW   = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_HALF = TW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    // With HALF=0 the start sample is the detect cycle itself, so START is skipped.
    localparam uart_state_e FIRST_ST = (HALF == 0) ? DATA : START;

    logic                 rx_s;
    uart_state_e          state, state_next;
    logic [TW-1:0]        tmr, tmr_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DATA_BITS-1:0] sr, sr_next;
    logic                 par, par_next;
    logic                 good_c, frame_c, load_c, overrun_c, tick_c;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx1),
        .q   (rx_s)
    );

    assign tick_c = (tmr == TMR_LAST);

    // Next-state, bit timer and sampling decisions.
    always_comb begin
        state_next = state;
        tmr_next   = tick_c ? '0 : tmr + TW'(1);
        idx_next   = idx;
        sr_next    = sr;
        par_next   = par;
        good_c     = 1'b0;
        frame_c    = 1'b0;

        case (state)
            IDLE: begin
                tmr_next = '0;
                idx_next = '0;
                if (rx_s == START_LEVEL) begin
                    state_next = FIRST_ST;
                end
            end
            START: begin
                if (tmr == TMR_HALF) begin
                    tmr_next   = '0;
                    state_next = (rx_s == START_LEVEL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (tick_c) begin
                    sr_next[idx] = rx_s;
                    if (idx == IDX_LAST) begin
                        state_next = PARITY;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick_c) begin
                    par_next   = rx_s;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (rx_s == STOP_LEVEL) begin
                        good_c     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_c    = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s == IDLE_LEVEL) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An accept in the completion cycle frees the register, so no overrun.
    assign load_c    = good_c && (!data_valid || data_ready);
    assign overrun_c = good_c && data_valid && !data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= '0;
            sr    <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
            idx   <= idx_next;
            sr    <= sr_next;
            par   <= par_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            rx_active   <= 1'b0;
        end else begin
            if (load_c) begin
                data_out   <= sr;
                parity_err <= par ^ (^sr);
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            frame_err   <= frame_c;
            overrun_err <= overrun_c;
            rx_active   <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart1_rx.sv
// Directed bench for uart1_rx at CLKS_PER_BIT=1 and 16 with cycle-exact expectations.
module tb_uart1_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx1, rx16;
    logic       ready, ready16;
    logic [7:0] data_out, data_out16;
    logic       data_valid, parity_err, frame_err, overrun_err, rx_active;
    logic       data_valid16, parity_err16, frame_err16, overrun_err16, rx_active16;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int t_start;

    // Event records, filled at negedge by the monitor below.
    int dv_rise, dv_cnt, fe_cnt, fe_cyc, oe_cnt, oe_cyc, act_first, act_last;
    logic [7:0] dv_data;
    logic       dv_perr;
    int dv16_rise, act16_cnt, act16_first, act16_last, flag16_cnt;
    logic [7:0] dv16_data;
    logic       dv16_perr;

    uart1_rx #(.CLKS_PER_BIT(1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx1         (rx1),
        .data_ready  (ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_active   (rx_active)
    );

    uart1_rx #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .rx1         (rx16),
        .data_ready  (ready16),
        .data_out    (data_out16),
        .data_valid  (data_valid16),
        .parity_err  (parity_err16),
        .frame_err   (frame_err16),
        .overrun_err (overrun_err16),
        .rx_active   (rx_active16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            if (dv_rise < 0) begin
                dv_rise = cyc;
                dv_data = data_out;
                dv_perr = parity_err;
            end
        end
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (overrun_err) begin oe_cnt++; oe_cyc = cyc; end
        if (rx_active) begin
            if (act_first < 0) act_first = cyc;
            act_last = cyc;
        end
        if (data_valid16 && dv16_rise < 0) begin
            dv16_rise = cyc;
            dv16_data = data_out16;
            dv16_perr = parity_err16;
        end
        if (rx_active16) begin
            act16_cnt++;
            if (act16_first < 0) act16_first = cyc;
            act16_last = cyc;
        end
        if (frame_err16 || overrun_err16) flag16_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        dv_rise = -1; dv_cnt = 0; fe_cnt = 0; fe_cyc = -1; oe_cnt = 0; oe_cyc = -1;
        act_first = -1; act_last = -1; dv_data = '0; dv_perr = 1'b0;
        dv16_rise = -1; act16_cnt = 0; act16_first = -1; act16_last = -1;
        flag16_cnt = 0; dv16_data = '0; dv16_perr = 1'b0;
    endtask

    // Drives the first nbits of a frame (start, d[0..7], parity, stop).
    task automatic send_frame(input bit wide, input logic [7:0] d, input logic p,
                              input logic s, input int nbits);
        logic [10:0] f;
        int          cpb;
        f   = {s, p, d, 1'b0};
        cpb = wide ? 16 : 1;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < cpb; j++) begin
                @(posedge clk);
                #1;
                if (wide) rx16 = f[i];
                else      rx1  = f[i];
                if (i == 0 && j == 0) t_start = cyc;
            end
        end
    endtask

    task automatic drive_line(input bit wide, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (wide) rx16 = v;
            else      rx1  = v;
        end
    endtask

    initial begin
        int t1, t0;
        rst = 1'b1; rx1 = 1'b1; rx16 = 1'b1; ready = 1'b1; ready16 = 1'b1;
        clear_mon();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_flags", int'({parity_err, frame_err, overrun_err}), 0);
        check("rst_active", int'(rx_active), 0);
        @(posedge clk); #1 rst = 1'b1;
        drive_line(0, 1'b1, 4);

        // 0xA5, good parity, timing of valid and rx_active.
        clear_mon();
        send_frame(0, 8'hA5, 1'b0, 1'b1, 11);
        drive_line(0, 1'b1, 6);
        check("a5_valid_cycle", dv_rise - t_start, 13);
        check("a5_valid_len", dv_cnt, 1);
        check("a5_data", int'(dv_data), 'hA5);
        check("a5_perr", int'(dv_perr), 0);
        check("a5_active_rise", act_first - t_start, 3);
        check("a5_active_last", act_last - t_start, 12);
        check("a5_no_flags", fe_cnt + oe_cnt, 0);

        // 0x3C with wrong parity bit, then 0x07 with correct odd-weight parity.
        clear_mon();
        send_frame(0, 8'h3C, 1'b1, 1'b1, 11);
        drive_line(0, 1'b1, 6);
        check("3c_data", int'(dv_data), 'h3C);
        check("3c_perr", int'(dv_perr), 1);
        check("3c_valid_len", dv_cnt, 1);
        clear_mon();
        send_frame(0, 8'h07, 1'b1, 1'b1, 11);
        drive_line(0, 1'b1, 6);
        check("07_data", int'(dv_data), 'h07);
        check("07_perr", int'(dv_perr), 0);

        // Stop bit low, line held low: framing pulse and wait for idle.
        clear_mon();
        send_frame(0, 8'h00, 1'b0, 1'b0, 11);
        drive_line(0, 1'b0, 5);
        drive_line(0, 1'b1, 8);
        check("fe_count", fe_cnt, 1);
        check("fe_cycle", fe_cyc - t_start, 13);
        check("fe_no_valid", dv_cnt, 0);
        check("fe_active_last", act_last - t_start, 18);

        // CLKS_PER_BIT=16 false start of 4 cycles.
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 rx16 = 1'b0;
            if (i == 0) t0 = cyc;
        end
        drive_line(1, 1'b1, 40);
        check("fs_active_rise", act16_first - t0, 3);
        check("fs_active_last", act16_last - t0, 9);
        check("fs_active_cnt", act16_cnt, 7);
        check("fs_no_flags", flag16_cnt, 0);
        check("fs_no_valid", dv16_rise, -1);

        // CLKS_PER_BIT=16 full frame 0x96.
        clear_mon();
        send_frame(1, 8'h96, 1'b0, 1'b1, 11);
        drive_line(1, 1'b1, 4);
        check("w16_valid_cycle", dv16_rise - t_start, 170);
        check("w16_data", int'(dv16_data), 'h96);
        check("w16_perr", int'(dv16_perr), 0);

        // Overrun: ready low, 0x11 then 0x22 with a 1-cycle gap.
        ready = 1'b0;
        clear_mon();
        send_frame(0, 8'h11, 1'b0, 1'b1, 11);
        drive_line(0, 1'b1, 1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 11);
        drive_line(0, 1'b1, 6);
        check("ovr_count", oe_cnt, 1);
        check("ovr_cycle", oe_cyc - t_start, 13);
        @(negedge clk);
        check("ovr_data_kept", int'(data_out), 'h11);
        check("ovr_valid_held", int'(data_valid), 1);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ovr_valid_cleared", int'(data_valid), 0);

        // Accept in the same cycle as frame completion: no overrun, new byte loads.
        ready = 1'b0;
        clear_mon();
        send_frame(0, 8'h11, 1'b0, 1'b1, 11);
        drive_line(0, 1'b1, 1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 11);
        drive_line(0, 1'b1, 1);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        check("aw_valid", int'(data_valid), 1);
        check("aw_data", int'(data_out), 'h22);
        drive_line(0, 1'b1, 3);
        check("aw_no_overrun", oe_cnt, 0);

        // Reset during data bit 4, then a clean 0x5A.
        clear_mon();
        send_frame(0, 8'hFF, 1'b0, 1'b1, 8);
        #2 rst = 1'b0;
        #1;
        check("mr_was_active", act_first - t_start, 3);
        check("mr_data_out", int'(data_out), 0);
        check("mr_valid", int'(data_valid), 0);
        check("mr_active", int'(rx_active), 0);
        rx1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; ready = 1'b1;
        drive_line(0, 1'b1, 4);
        clear_mon();
        send_frame(0, 8'h5A, 1'b0, 1'b1, 11);
        drive_line(0, 1'b1, 6);
        check("5a_valid_cycle", dv_rise - t_start, 13);
        check("5a_data", int'(dv_data), 'h5A);
        check("5a_perr", int'(dv_perr), 0);
        check("5a_no_flags", fe_cnt + oe_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart1_rx.md
# uart1_rx

Receive end of the UART1 serial link. Deserializes the `tx1` line format: 1 start bit (0), 8 data bits LSB-first, 1 even-parity bit (XOR of the data), and 1 stop bit (1), with the line idling high. It delivers each byte on a valid/ready parallel port with parity, framing and overrun flags. It sits between the serial pin and the parallel consumer.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit, legal range 1..65535. The default of 1 matches the one-bit-per-clock transmitter.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserted at 0.
- `rx1`  in  1  serial line, idles high; asynchronous to `clk`.
- `data_ready`  in  1  consumer accepts `data_out` when high together with `data_valid`.
- `data_out`  out  8  received byte.
- `data_valid`  out  1  `data_out` holds an unaccepted byte.
- `parity_err`  out  1  parity mismatch for the byte in `data_out`; qualified by `data_valid`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `overrun_err`  out  1  one-cycle pulse when a good frame completes while `data_valid` is high.
- `rx_active`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation

- `rx1` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- Let HALF = (CLKS_PER_BIT-1)/2, using integer division.
- Let D = the first cycle in IDLE with `rx_s`=0. Sample k is taken at cycle D + HALF + k·CLKS_PER_BIT:
  - k=0: start check
  - k=1..8: data bits 0..7
  - k=9: parity
  - k=10: stop
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when `rx_s`=0, go to START (cycle D), clear the bit timer and bit index.
- START:
  - If the k=0 sample is 1, this is a false start: return to IDLE with no outputs.
  - Otherwise go to DATA.
- DATA: shift the sample into bit[index], LSB first. After bit 7, go to PARITY.
- PARITY: latch the sample. Computed error = sample XOR (^data).
- STOP, at the k=10 sample:
  - Stop = 1 and `data_valid`=0: load `data_out` and `parity_err`, set `data_valid`, go to IDLE.
  - Stop = 1 and `data_valid`=1: drop the new byte. `data_out` and `parity_err` are unchanged. Pulse `overrun_err`. Go to IDLE.
  - Stop = 0: drop the byte, pulse `frame_err`, go to WAIT_IDLE.
- WAIT_IDLE: go to IDLE in the first cycle with `rx_s`=1. This prevents a break or stuck-low line from looking like a new start.
- `data_valid` clears on the edge where `data_valid && data_ready`.
- Simultaneous accept and frame completion in the same cycle: the accept wins first, so there is no overrun. The new byte loads and `data_valid` stays 1.
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `rx_active`=0, state IDLE, synchronizer=1.
- Reset mid-frame aborts the frame with no flags.

## Timing

- Latency from the `rx1` falling edge (cycle T) to D is 2 cycles.
- `data_valid`, `frame_err` and `overrun_err` take effect on the edge ending cycle D+HALF+10·CLKS_PER_BIT. They are visible one cycle later.
- With CLKS_PER_BIT=1: `data_valid` is visible at T+13.
- After a good frame, the receiver is in IDLE one cycle after the stop sample. It accepts a back-to-back frame with a 1-cycle idle gap.
- `rx_active` rises in cycle D+1 and falls the cycle after leaving STOP or WAIT_IDLE.
- The bit timer is ceil(log2(CLKS_PER_BIT)) bits wide, minimum 1. It wraps to 0 at CLKS_PER_BIT-1.

## Structure

- Package `uart_pkg` holds:
  - the state enum shared with the transmitter (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5)
  - DATA_BITS=8
  - START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1
- Sub-module `uart_sync2`: a 2-flop synchronizer with reset value 1.
- The bit timer, FSM and output register stay in `uart1_rx`.

## Test plan

- CLKS_PER_BIT=1, send 0xA5 (serial 0,1,0,1,0,0,1,0,1,parity 0,stop 1) with `data_ready`=1 → `data_out`=0xA5, `data_valid` high for 1 cycle at T+13, `parity_err`=0.
- Send 0x3C with parity bit 1 → `data_out`=0x3C, `data_valid`=1, `parity_err`=1.
- Send 0x00 with stop bit 0, line held low 5 more cycles → no `data_valid`, `frame_err` 1-cycle pulse. No new frame starts until the line has been high for 1 cycle.
- CLKS_PER_BIT=16, pull `rx1` low for 4 cycles → no sample taken as valid, FSM back in IDLE, `rx_active` pulses only during the false start, no flags.
- `data_ready`=0, send 0x11 then 0x22 back-to-back → `data_out` stays 0x11, `overrun_err` pulses at the 0x22 stop sample. Raising `data_ready` then clears `data_valid`.
- Assert `rst`=0 during data bit 4 of a frame → all outputs 0 immediately. The next full frame 0x5A is received correctly.
